// File: rtl/cond_it_unit_if.sv
// Execute-stage condition/flags bus: instruction controls and flag sources in, condition
// result, flags and IT status out.
interface cond_it_unit_if #(
  parameter int NSRC = 2,
  parameter int SELW = (NSRC > 1) ? $clog2(NSRC) : 1
);
  logic                StallE;
  logic                FlushE;
  logic                ITClear;
  logic                InstrValidE;
  logic [3:0]          Cond;
  logic [4*NSRC-1:0]   SrcFlagsE;
  logic [SELW-1:0]     SrcSelE;
  logic [1:0]          FlagsWrite;
  logic                ITStartE;
  logic [3:0]          ITFirstCond;
  logic [3:0]          ITMask;
  logic                CondEx;
  logic [3:0]          EffCondE;
  logic [3:0]          Flags;
  logic [3:0]          FlagsNext;
  logic                ITActive;

  modport master (
    output StallE, FlushE, ITClear, InstrValidE, Cond, SrcFlagsE, SrcSelE,
           FlagsWrite, ITStartE, ITFirstCond, ITMask,
    input  CondEx, EffCondE, Flags, FlagsNext, ITActive
  );

  modport slave (
    input  StallE, FlushE, ITClear, InstrValidE, Cond, SrcFlagsE, SrcSelE,
           FlagsWrite, ITStartE, ITFirstCond, ITMask,
    output CondEx, EffCondE, Flags, FlagsNext, ITActive
  );
endinterface

// File: rtl/cond_it_unit.sv
// Execute-stage condition evaluation, NZCV flag register with multi-source write mux,
// and Thumb-2 IT-block state (ARM ITSTATE layout).
module cond_it_unit #(
  parameter int NSRC  = 2,
  parameter bit IT_EN = 1'b1,
  parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic         clk,
  input  logic         reset,
  cond_it_unit_if.slave bus
);

  logic [3:0] flags_q, flags_d;
  logic [7:0] it_q, it_d;
  logic [3:0] eff_cond;
  logic [3:0] sel_flags;
  logic       pass;
  logic       cond_ex;
  logic       upd;
  logic       it_active;
  logic       it_start_ok;
  logic       n, z, c, v;

  assign upd       = bus.InstrValidE & ~bus.StallE & ~bus.FlushE;
  assign it_active = |it_q[3:0];
  assign eff_cond  = it_active ? it_q[7:4] : bus.Cond;
  assign {n, z, c, v} = flags_q;

  always_comb begin
    pass = 1'b0;
    unique case (eff_cond)
      4'h0: pass = z;
      4'h1: pass = ~z;
      4'h2: pass = c;
      4'h3: pass = ~c;
      4'h4: pass = n;
      4'h5: pass = ~n;
      4'h6: pass = v;
      4'h7: pass = ~v;
      4'h8: pass = c & ~z;
      4'h9: pass = ~c | z;
      4'hA: pass = (n == v);
      4'hB: pass = (n != v);
      4'hC: pass = ~z & (n == v);
      4'hD: pass = z | (n != v);
      4'hE: pass = 1'b1;
      4'hF: pass = 1'b0;
    endcase
  end

  assign cond_ex = bus.InstrValidE & pass;

  // Out-of-range selects fall back to source 0.
  always_comb begin
    sel_flags = bus.SrcFlagsE[3:0];
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (bus.SrcSelE == SELW'(k)) sel_flags = bus.SrcFlagsE[4*k +: 4];
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (bus.FlagsWrite[1] & cond_ex) flags_d[3:2] = sel_flags[3:2];
    if (bus.FlagsWrite[0] & cond_ex) flags_d[1:0] = sel_flags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset)    flags_q <= '0;
    else if (upd) flags_q <= flags_d;
  end

  assign it_start_ok = bus.ITStartE & ~it_active & (|bus.ITMask) & (bus.ITFirstCond != 4'hF);

  // Base condition [7:5] is held; [4:0] shifts so [4] supplies each slot's condition LSB.
  always_comb begin
    it_d = it_q;
    if (upd) begin
      if (it_start_ok) begin
        it_d = {bus.ITFirstCond, bus.ITMask};
      end else if (it_active) begin
        if (it_q[2:0] == 3'b000) it_d = '0;
        else                     it_d = {it_q[7:5], it_q[3:0], 1'b0};
      end
    end
  end

  generate
    if (IT_EN) begin : g_it
      always_ff @(posedge clk) begin
        if (reset | bus.ITClear) it_q <= '0;
        else                     it_q <= it_d;
      end
    end else begin : g_no_it
      always_comb it_q = '0;
    end
  endgenerate

  assign bus.CondEx    = cond_ex;
  assign bus.EffCondE  = eff_cond;
  assign bus.Flags     = flags_q;
  assign bus.FlagsNext = flags_d;
  assign bus.ITActive  = it_active;

endmodule

// File: tb/tb_cond_it_unit.sv
// Scoreboard bench for cond_it_unit: stimulus pushes expected outputs from a queue-based
// IT model and NZCV model; a negedge monitor pops and compares.
module tb_cond_it_unit;

  localparam int NSRC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cond_it_unit_if #(.NSRC(NSRC)) bus();

  cond_it_unit #(.NSRC(NSRC), .IT_EN(1'b1)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic       cx;
    logic [3:0] eff;
    logic [3:0] fn;
    logic [3:0] fl;
    logic       act;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] itq[$];
  logic [3:0] flags_m = 4'b0000;
  logic [3:0] src[NSRC];
  int         tests = 0;
  int         fails = 0;

  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;                4'h1: return !z;
      4'h2: return c;                4'h3: return !c;
      4'h4: return n;                4'h5: return !n;
      4'h6: return v;                4'h7: return !v;
      4'h8: return c && !z;          4'h9: return !c || z;
      4'hA: return n == v;           4'hB: return n != v;
      4'hC: return !z && (n == v);   4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expand an IT instruction into the list of per-slot conditions.
  task automatic it_expand(input logic [3:0] fc, input logic [3:0] mask);
    int lsb = 0;
    while (!mask[lsb]) lsb++;
    itq.push_back(fc);
    for (int i = 2; i <= 4 - lsb; i++) itq.push_back({fc[3:1], mask[5-i]});
  endtask

  task automatic step(input bit chk);
    exp_t       e;
    logic [3:0] eff, sel, fn;
    logic       cx;
    bit         upd;
    int         s;
    bus.SrcFlagsE = {src[2], src[1], src[0]};
    upd = bus.InstrValidE && !bus.StallE && !bus.FlushE;
    eff = (itq.size() != 0) ? itq[0] : bus.Cond;
    cx  = bus.InstrValidE && cond_pass(eff, flags_m);
    s   = int'(bus.SrcSelE);
    sel = (s < NSRC) ? src[s] : src[0];
    fn  = flags_m;
    if (bus.FlagsWrite[1] && cx) fn[3:2] = sel[3:2];
    if (bus.FlagsWrite[0] && cx) fn[1:0] = sel[1:0];
    e = '{cx: cx, eff: eff, fn: fn, fl: flags_m, act: itq.size() != 0};
    if (chk) sbq.push_back(e);
    if (rst) begin
      flags_m = 4'b0000;
      itq.delete();
    end else begin
      if (upd) flags_m = fn;
      if (bus.ITClear) itq.delete();
      else if (upd) begin
        if (bus.ITStartE && itq.size() == 0 && bus.ITMask != 0 && bus.ITFirstCond != 4'hF)
          it_expand(bus.ITFirstCond, bus.ITMask);
        else if (itq.size() != 0)
          void'(itq.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("CondEx",    {3'b0, bus.CondEx},   {3'b0, e.cx});
      check("EffCondE",  bus.EffCondE,         e.eff);
      check("FlagsNext", bus.FlagsNext,        e.fn);
      check("Flags",     bus.Flags,            e.fl);
      check("ITActive",  {3'b0, bus.ITActive}, {3'b0, e.act});
    end
  end

  task automatic set_in(input logic v, input logic [3:0] cond, input logic [1:0] fw,
                        input logic [1:0] sel);
    bus.InstrValidE = v;
    bus.Cond        = cond;
    bus.FlagsWrite  = fw;
    bus.SrcSelE     = sel;
    bus.StallE      = 1'b0;
    bus.FlushE      = 1'b0;
    bus.ITClear     = 1'b0;
    bus.ITStartE    = 1'b0;
  endtask

  task automatic it_start(input logic [3:0] fc, input logic [3:0] mask);
    set_in(1'b1, 4'hE, 2'b00, 2'd0);
    bus.ITStartE    = 1'b1;
    bus.ITFirstCond = fc;
    bus.ITMask      = mask;
    step(1);
  endtask

  initial begin
    for (int k = 0; k < NSRC; k++) src[k] = 4'h0;
    set_in(1'b0, 4'hE, 2'b00, 2'd0);
    bus.ITFirstCond = 4'h0;
    bus.ITMask      = 4'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    step(0);
    step(1);
    rst = 1'b0;

    // Unconditional write of all flags, then observe them.
    src[0] = 4'b1001; set_in(1'b1, 4'hE, 2'b11, 2'd0); step(1);
    set_in(1'b1, 4'hE, 2'b00, 2'd0); step(1);
    // Z only: EQ passes, NE fails, NV never passes and never writes.
    src[0] = 4'b0100; set_in(1'b1, 4'hE, 2'b11, 2'd0); step(1);
    set_in(1'b1, 4'h0, 2'b00, 2'd0); step(1);
    set_in(1'b1, 4'h1, 2'b00, 2'd0); step(1);
    src[0] = 4'b1111; set_in(1'b1, 4'hF, 2'b11, 2'd0); step(1);
    // Partial N,Z write from source 1; then a failing condition keeps flags.
    src[0] = 4'b0011; set_in(1'b1, 4'hE, 2'b11, 2'd0); step(1);
    src[1] = 4'b1100; set_in(1'b1, 4'hE, 2'b10, 2'd1); step(1);
    set_in(1'b1, 4'hE, 2'b11, 2'd0); step(1);
    set_in(1'b1, 4'h0, 2'b10, 2'd1); step(1);
    // Out-of-range select falls back to source 0; invalid instruction never passes.
    src[0] = 4'b0110; src[2] = 4'b1000; set_in(1'b1, 4'hE, 2'b11, 2'd3); step(1);
    set_in(1'b0, 4'hE, 2'b11, 2'd2); step(1);

    // ITTE EQ block with a stall in the middle.
    it_start(4'h0, 4'b0110);
    set_in(1'b1, 4'hE, 2'b00, 2'd0); step(1);
    bus.StallE = 1'b1; bus.FlagsWrite = 2'b11; step(1);
    bus.StallE = 1'b0; bus.FlagsWrite = 2'b00; step(1);
    bus.ITStartE = 1'b1; bus.ITFirstCond = 4'h2; bus.ITMask = 4'b1000; step(1);
    set_in(1'b1, 4'hE, 2'b00, 2'd0); step(1);
    // Degenerate IT encodings are ignored.
    bus.ITStartE = 1'b1; bus.ITFirstCond = 4'h3; bus.ITMask = 4'b0000; step(1);
    bus.ITStartE = 1'b1; bus.ITFirstCond = 4'hF; bus.ITMask = 4'b1000; step(1);
    set_in(1'b1, 4'hE, 2'b00, 2'd0); step(1);

    // Clear and flush inside a block.
    it_start(4'hA, 4'b0001);
    set_in(1'b1, 4'h4, 2'b00, 2'd0); bus.FlushE = 1'b1; step(1);
    bus.FlushE = 1'b0; step(1);
    src[0] = 4'b0001; bus.FlagsWrite = 2'b11; bus.ITClear = 1'b1; step(1);
    set_in(1'b1, 4'h6, 2'b00, 2'd0); step(1);

    // Reset in the middle of an IT block.
    it_start(4'hE, 4'b0010);
    set_in(1'b1, 4'hE, 2'b00, 2'd0); rst = 1'b1; step(1);
    rst = 1'b0; step(1);

    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NSRC; k++) src[k] = 4'($urandom);
      bus.InstrValidE = ($urandom_range(0, 99) < 85);
      bus.StallE      = ($urandom_range(0, 99) < 10);
      bus.FlushE      = ($urandom_range(0, 99) < 8);
      bus.ITClear     = ($urandom_range(0, 99) < 3);
      bus.ITStartE    = ($urandom_range(0, 99) < 20);
      bus.Cond        = 4'($urandom);
      bus.ITFirstCond = 4'($urandom);
      bus.ITMask      = 4'($urandom);
      bus.FlagsWrite  = 2'($urandom);
      bus.SrcSelE     = 2'($urandom);
      rst             = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;
    set_in(1'b0, 4'hE, 2'b00, 2'd0);

    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
